// File: rtl/dog_stream_gen_if.sv
// Stream bundle for the DoG stage: Gaussian pixels in, offset/saturated DoG pixels out.
interface dog_stream_gen_if #(
   parameter int DATA_W = 8,
   parameter int SCALES = 5
);
   logic                         in_valid;
   logic                         in_sof;
   logic [SCALES*DATA_W-1:0]     in_gauss;
   logic                         out_valid;
   logic [(SCALES-1)*DATA_W-1:0] out_dog;
   logic [15:0]                  out_x;
   logic [15:0]                  out_y;
   logic                         out_border;
   logic                         out_eof;
   logic                         sof_err;

   modport master (
      output in_valid, in_sof, in_gauss,
      input  out_valid, out_dog, out_x, out_y, out_border, out_eof, sof_err
   );

   modport slave (
      input  in_valid, in_sof, in_gauss,
      output out_valid, out_dog, out_x, out_y, out_border, out_eof, sof_err
   );
endinterface

// File: rtl/dog_stream_gen.sv
// Streaming Difference-of-Gaussian stage: frame tracking, decimation, border tagging,
// offset/saturated differences, then a fixed-latency delay line.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for in_valid & in_sof; other pixels are ignored
//   ST_RUN  | inside a frame; every in_valid advances the x/y counters
module dog_stream_gen #(
   parameter int DATA_W     = 8,
   parameter int SCALES     = 5,
   parameter int FRAME_W    = 200,
   parameter int FRAME_H    = 200,
   parameter int BORDER     = 9,
   parameter int DOWN_S     = 0,
   parameter int DOG_OFFSET = 128,
   parameter int PIPE       = 2
) (
   input  logic            pixClk,
   input  logic            rst,
   dog_stream_gen_if.slave bus
);
   localparam int DOG_W = (SCALES-1)*DATA_W;
   localparam int MAX_V = (1 << DATA_W) - 1;

   localparam logic [15:0] DEC_MASK = 16'((1 << DOWN_S) - 1);
   localparam logic [15:0] X_LAST   = 16'(FRAME_W-1);
   localparam logic [15:0] Y_LAST   = 16'(FRAME_H-1);
   localparam logic [15:0] X_EOF    = X_LAST & ~DEC_MASK;
   localparam logic [15:0] Y_EOF    = Y_LAST & ~DEC_MASK;
   localparam logic [15:0] BDR_LO   = 16'(BORDER);
   localparam logic [15:0] BDR_XHI  = 16'(FRAME_W-BORDER);
   localparam logic [15:0] BDR_YHI  = 16'(FRAME_H-BORDER);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [15:0] x_q, x_d, y_q, y_d;
   logic        sof_err_q, sof_err_d;

   logic        accept, take, is_border, is_eof;
   logic [15:0] px, py;
   logic [DOG_W-1:0] dog_d;

   function automatic logic [DATA_W-1:0] sat_dog(input logic [DATA_W-1:0] g_lo,
                                                   input logic [DATA_W-1:0] g_hi);
      int s;
      s = int'(g_hi) - int'(g_lo) + DOG_OFFSET;
      if (s < 0) return '0;
      if (s > MAX_V) return '1;
      return s[DATA_W-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      sof_err_d = 1'b0;
      accept    = 1'b0;
      px        = x_q;
      py        = y_q;
      if (bus.in_valid) begin
         if (bus.in_sof) begin
            // a start-of-frame always wins, even mid-frame: the old frame is abandoned
            accept    = 1'b1;
            px        = '0;
            py        = '0;
            sof_err_d = (state_q == ST_RUN);
            state_d   = ST_RUN;
         end else if (state_q == ST_RUN) begin
            accept = 1'b1;
         end
      end
      if (accept) begin
         if (px == X_LAST) begin
            x_d = '0;
            if (py == Y_LAST) begin
               y_d     = '0;
               state_d = ST_IDLE;
            end else begin
               y_d = py + 16'd1;
            end
         end else begin
            x_d = px + 16'd1;
            y_d = py;
         end
      end
   end

   always_ff @(posedge pixClk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         sof_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         sof_err_q <= sof_err_d;
      end
   end

   always_comb begin
      take      = accept && ((px & DEC_MASK) == '0) && ((py & DEC_MASK) == '0);
      is_border = (px < BDR_LO) || (px >= BDR_XHI) || (py < BDR_LO) || (py >= BDR_YHI);
      is_eof    = (px == X_EOF) && (py == Y_EOF);
      dog_d     = '0;
      for (int i = 0; i < SCALES-1; i++) begin
         dog_d[i*DATA_W +: DATA_W] = is_border ? DATA_W'(DOG_OFFSET)
            : sat_dog(bus.in_gauss[i*DATA_W +: DATA_W], bus.in_gauss[(i+1)*DATA_W +: DATA_W]);
      end
   end

   logic [PIPE-1:0]  vld_q, eof_q, bdr_q;
   logic [DOG_W-1:0] dog_q [PIPE];
   logic [15:0]      ox_q  [PIPE];
   logic [15:0]      oy_q  [PIPE];

   // data registers load only behind a valid, so outputs hold through bubbles
   always_ff @(posedge pixClk) begin
      if (!rst) begin
         vld_q <= '0;
         eof_q <= '0;
         bdr_q <= '0;
         for (int i = 0; i < PIPE; i++) begin
            dog_q[i] <= '0;
            ox_q[i]  <= '0;
            oy_q[i]  <= '0;
         end
      end else begin
         vld_q[0] <= take;
         eof_q[0] <= take & is_eof;
         if (take) begin
            bdr_q[0] <= is_border;
            dog_q[0] <= dog_d;
            ox_q[0]  <= px >> DOWN_S;
            oy_q[0]  <= py >> DOWN_S;
         end
         for (int i = 1; i < PIPE; i++) begin
            vld_q[i] <= vld_q[i-1];
            eof_q[i] <= eof_q[i-1];
            if (vld_q[i-1]) begin
               bdr_q[i] <= bdr_q[i-1];
               dog_q[i] <= dog_q[i-1];
               ox_q[i]  <= ox_q[i-1];
               oy_q[i]  <= oy_q[i-1];
            end
         end
      end
   end

   assign bus.out_valid  = vld_q[PIPE-1];
   assign bus.out_eof    = eof_q[PIPE-1];
   assign bus.out_border = bdr_q[PIPE-1];
   assign bus.out_dog    = dog_q[PIPE-1];
   assign bus.out_x      = ox_q[PIPE-1];
   assign bus.out_y      = oy_q[PIPE-1];
   assign bus.sof_err    = sof_err_q;
endmodule

// File: tb/tb_dog_stream_gen.sv
// Bench for dog_stream_gen: three 8x4 instances (bordered, border-free, decimated) share one
// stimulus stream and are checked against a frame-level reference model.
module tb_dog_stream_gen;
   localparam int FW = 8;
   localparam int FH = 4;
   localparam int PIPE = 2;

   typedef struct packed {
      logic        v;
      logic [15:0] dog;
      logic [15:0] x;
      logic [15:0] y;
      logic        b;
      logic        e;
   } rec_t;

   logic        pixClk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [23:0] in_gauss = '0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 pixClk = ~pixClk;

   dog_stream_gen_if #(.DATA_W(8), .SCALES(3)) ifa ();
   dog_stream_gen_if #(.DATA_W(8), .SCALES(3)) ifb ();
   dog_stream_gen_if #(.DATA_W(8), .SCALES(3)) ifc ();

   assign ifa.in_valid = in_valid;  assign ifa.in_sof = in_sof;  assign ifa.in_gauss = in_gauss;
   assign ifb.in_valid = in_valid;  assign ifb.in_sof = in_sof;  assign ifb.in_gauss = in_gauss;
   assign ifc.in_valid = in_valid;  assign ifc.in_sof = in_sof;  assign ifc.in_gauss = in_gauss;

   dog_stream_gen #(.DATA_W(8), .SCALES(3), .FRAME_W(FW), .FRAME_H(FH), .BORDER(1), .DOWN_S(0),
                    .DOG_OFFSET(128), .PIPE(PIPE)) dut_a (.pixClk(pixClk), .rst(rst), .bus(ifa));
   dog_stream_gen #(.DATA_W(8), .SCALES(3), .FRAME_W(FW), .FRAME_H(FH), .BORDER(0), .DOWN_S(0),
                    .DOG_OFFSET(128), .PIPE(PIPE)) dut_b (.pixClk(pixClk), .rst(rst), .bus(ifb));
   dog_stream_gen #(.DATA_W(8), .SCALES(3), .FRAME_W(FW), .FRAME_H(FH), .BORDER(1), .DOWN_S(1),
                    .DOG_OFFSET(128), .PIPE(PIPE)) dut_c (.pixClk(pixClk), .rst(rst), .bus(ifc));

   rec_t       act [3];
   logic [2:0] act_se;
   assign act[0] = {ifa.out_valid, ifa.out_dog, ifa.out_x, ifa.out_y, ifa.out_border, ifa.out_eof};
   assign act[1] = {ifb.out_valid, ifb.out_dog, ifb.out_x, ifb.out_y, ifb.out_border, ifb.out_eof};
   assign act[2] = {ifc.out_valid, ifc.out_dog, ifc.out_x, ifc.out_y, ifc.out_border, ifc.out_eof};
   assign act_se = {ifc.sof_err, ifb.sof_err, ifa.sof_err};

   // Reference model: a frame is a run of FW*FH accepted pixels numbered 0..FW*FH-1.
   function automatic rec_t model_pix(input int k, input int x, input int y, input logic [23:0] g);
      rec_t r;
      int dec, bw, s;
      dec = (k == 2) ? 2 : 1;
      bw  = (k == 1) ? 0 : 1;
      r   = '0;
      if ((x % dec) != 0 || (y % dec) != 0) return r;
      r.v = 1'b1;
      r.x = 16'(x / dec);
      r.y = 16'(y / dec);
      r.b = (x < bw) || (x >= FW - bw) || (y < bw) || (y >= FH - bw);
      for (int i = 0; i < 2; i++) begin
         s = int'(g[(i+1)*8 +: 8]) - int'(g[i*8 +: 8]) + 128;
         if (s < 0) s = 0;
         if (s > 255) s = 255;
         if (r.b) s = 128;
         r.dog[i*8 +: 8] = 8'(s);
      end
      r.e = (x == ((FW-1)/dec)*dec) && (y == ((FH-1)/dec)*dec);
      return r;
   endfunction

   rec_t mq [3][$];
   rec_t exp_r [3];
   logic exp_se = 1'b0;
   int   in_frame = 0;
   int   pidx = 0;

   always @(posedge pixClk) begin : model
      rec_t r, o;
      logic acc;
      if (!rst) begin
         in_frame = 0;
         pidx     = 0;
         exp_se   = 1'b0;
         for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            for (int j = 0; j < PIPE-1; j++) mq[k].push_back('0);
            exp_r[k] = '0;
         end
      end else begin
         acc    = 1'b0;
         exp_se = 1'b0;
         if (in_valid) begin
            if (in_sof) begin
               exp_se   = (in_frame != 0);
               in_frame = 1;
               pidx     = 0;
               acc      = 1'b1;
            end else if (in_frame != 0) begin
               acc = 1'b1;
            end
         end
         for (int k = 0; k < 3; k++) begin
            r = acc ? model_pix(k, pidx % FW, pidx / FW, in_gauss) : '0;
            mq[k].push_back(r);
            o = mq[k].pop_front();
            if (o.v) exp_r[k] = o;
            else begin
               exp_r[k].v = 1'b0;
               exp_r[k].e = 1'b0;
            end
         end
         if (acc) begin
            pidx++;
            if (pidx == FW*FH) begin
               in_frame = 0;
               pidx     = 0;
            end
         end
      end
   end

   task automatic step(input logic v, input logic s, input logic [23:0] g);
      @(negedge pixClk);
      in_valid = v;
      in_sof   = s;
      in_gauss = g;
      @(posedge pixClk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(0, 0, '0);
      step(0, 0, '0);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      step(1, 1, $urandom);
      for (int i = 0; i < 5; i++) step(1, 0, $urandom);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, $urandom);
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act[k] !== '0) begin
               n_err++;
               $display("FAIL reset_outputs dut%0d: got %h want 0", k, act[k]);
            end
         end
         n_cmp++;
         if (act_se !== 3'b000) begin
            n_err++;
            $display("FAIL reset_sof_err: got %b want 000", act_se);
         end
      end
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, $urandom);
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act[k].v !== 1'b0 || act[k] !== exp_r[k]) begin
               n_err++;
               $display("FAIL post_reset_no_sof dut%0d: got %h want %h", k, act[k], exp_r[k]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      step(1, 1, {8'd128, 8'd255, 8'd0});
      n_cmp++;
      if (act[1].v !== 1'b0) begin
         n_err++;
         $display("FAIL sat_latency: out_valid got %b want 0", act[1].v);
      end
      step(1, 0, {8'd0, 8'd0, 8'd255});
      n_cmp++;
      if (act[1].v !== 1'b1 || act[1].dog !== 16'h01FF) begin
         n_err++;
         $display("FAIL sat_high: got v=%b dog=%h want v=1 dog=01ff", act[1].v, act[1].dog);
      end
      step(0, 0, '0);
      n_cmp++;
      if (act[1].v !== 1'b1 || act[1].dog !== 16'h8000) begin
         n_err++;
         $display("FAIL sat_low: got v=%b dog=%h want v=1 dog=8000", act[1].v, act[1].dog);
      end
      step(0, 0, '0);
      n_cmp++;
      if (act[1].v !== 1'b0 || act[1].dog !== 16'h8000 || act[1].e !== 1'b0) begin
         n_err++;
         $display("FAIL sat_hold: got %h want v=0 dog=8000 eof=0", act[1]);
      end
   endtask

   task automatic test_frame_sweep(input int gap);
      int cnt, nb, ne;
      do_reset();
      cnt = 0; nb = 0; ne = 0;
      for (int p = 0; p < FW*FH + PIPE + 2; p++) begin
         if (p < FW*FH) step(1, p == 0, $urandom);
         else           step(0, 0, $urandom);
         for (int g = 0; g <= gap; g++) begin
            if (g > 0) step(0, 0, $urandom);
            for (int k = 0; k < 3; k++) begin
               n_cmp++;
               if (act[k] !== exp_r[k]) begin
                  n_err++;
                  $display("FAIL sweep_gap%0d dut%0d: got %h want %h", gap, k, act[k], exp_r[k]);
               end
            end
            if (act[0].v) begin
               n_cmp++;
               if (act[0].x !== 16'(cnt % FW) || act[0].y !== 16'(cnt / FW)) begin
                  n_err++;
                  $display("FAIL sweep_xy: got (%0d,%0d) want (%0d,%0d)",
                           act[0].x, act[0].y, cnt % FW, cnt / FW);
               end
               if (act[0].b) begin
                  nb++;
                  n_cmp++;
                  if (act[0].dog !== 16'h8080) begin
                     n_err++;
                     $display("FAIL sweep_border_dog: got %h want 8080", act[0].dog);
                  end
               end
               if (act[0].e) begin
                  ne++;
                  n_cmp++;
                  if (act[0].x !== 16'd7 || act[0].y !== 16'd3) begin
                     n_err++;
                     $display("FAIL sweep_eof_pos: got (%0d,%0d) want (7,3)", act[0].x, act[0].y);
                  end
               end
               cnt++;
            end
         end
      end
      n_cmp++;
      if (cnt != 32 || nb != 20 || ne != 1) begin
         n_err++;
         $display("FAIL sweep_counts: got out=%0d border=%0d eof=%0d want 32/20/1", cnt, nb, ne);
      end
   endtask

   task automatic test_decimation();
      int cnt, ne;
      do_reset();
      cnt = 0; ne = 0;
      for (int p = 0; p < FW*FH + PIPE + 2; p++) begin
         step(p < FW*FH, p == 0, $urandom);
         n_cmp++;
         if (act[2] !== exp_r[2]) begin
            n_err++;
            $display("FAIL decim dut2: got %h want %h", act[2], exp_r[2]);
         end
         if (act[2].v) begin
            cnt++;
            n_cmp++;
            if (act[2].x > 16'd3 || act[2].y > 16'd1) begin
               n_err++;
               $display("FAIL decim_range: got (%0d,%0d) want x<=3 y<=1", act[2].x, act[2].y);
            end
            if (act[2].e) begin
               ne++;
               n_cmp++;
               if (act[2].x !== 16'd3 || act[2].y !== 16'd1) begin
                  n_err++;
                  $display("FAIL decim_eof_pos: got (%0d,%0d) want (3,1)", act[2].x, act[2].y);
               end
            end
         end
      end
      n_cmp++;
      if (cnt != 8 || ne != 1) begin
         n_err++;
         $display("FAIL decim_counts: got out=%0d eof=%0d want 8/1", cnt, ne);
      end
   endtask

   task automatic test_resync();
      int cnt, ne;
      logic seen;
      do_reset();
      for (int p = 0; p < 10; p++) step(1, p == 0, $urandom);
      step(1, 1, $urandom);
      n_cmp++;
      if (act_se !== 3'b111 || exp_se !== 1'b1) begin
         n_err++;
         $display("FAIL resync_pulse: got %b want 111", act_se);
      end
      cnt = 0; ne = 0; seen = 1'b0;
      for (int p = 0; p < 31 + PIPE + 2; p++) begin
         step(p < 31, 0, $urandom);
         if (p == 0) begin
            n_cmp++;
            if (act_se !== 3'b000) begin
               n_err++;
               $display("FAIL resync_pulse_len: got %b want 000", act_se);
            end
         end
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act[k] !== exp_r[k]) begin
               n_err++;
               $display("FAIL resync dut%0d: got %h want %h", k, act[k], exp_r[k]);
            end
         end
         if (act[0].v) begin
            if (!seen) begin
               seen = 1'b1;
               n_cmp++;
               if (act[0].x !== 16'd0 || act[0].y !== 16'd0) begin
                  n_err++;
                  $display("FAIL resync_first: got (%0d,%0d) want (0,0)", act[0].x, act[0].y);
               end
            end
            cnt++;
            if (act[0].e) ne++;
         end
      end
      n_cmp++;
      if (cnt != 32 || ne != 1) begin
         n_err++;
         $display("FAIL resync_counts: got out=%0d eof=%0d want 32/1", cnt, ne);
      end
   endtask

   task automatic test_back_to_back();
      int sent, na, nc;
      do_reset();
      sent = 0; na = 0; nc = 0;
      for (int c = 0; c < 400 && sent < 2*FW*FH + PIPE + 2; c++) begin
         if ($urandom_range(0, 3) == 0) step(0, 0, $urandom);
         else begin
            step(sent < 2*FW*FH, sent == 0 || sent == FW*FH, $urandom);
            sent++;
         end
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act[k] !== exp_r[k]) begin
               n_err++;
               $display("FAIL b2b dut%0d: got %h want %h", k, act[k], exp_r[k]);
            end
         end
         n_cmp++;
         if (act_se !== {3{exp_se}}) begin
            n_err++;
            $display("FAIL b2b_sof_err: got %b want %b", act_se, {3{exp_se}});
         end
         if (act[0].e) na++;
         if (act[2].e) nc++;
      end
      n_cmp++;
      if (na != 2 || nc != 2) begin
         n_err++;
         $display("FAIL b2b_eof_count: got a=%0d c=%0d want 2/2", na, nc);
      end
   endtask

   initial begin
      test_reset();
      test_saturation();
      test_frame_sweep(0);
      test_frame_sweep(2);
      test_decimation();
      test_resync();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dog_stream_gen.md
Name: dog_stream_gen

Overview:
Streaming Difference-of-Gaussian stage for the SIFT scale-space path. It takes SCALES co-registered Gaussian-filtered pixel streams (outputs of the MAC filter bank) and produces SCALES-1 offset, saturated DoG streams. Each output pixel carries frame coordinates, a border flag and end-of-frame marking, with optional power-of-two decimation. It sits between the Gaussian MAC bank and the extremum detector and BMP writers.

Parameters:
DATA_W, 8, pixel/Gaussian sample width (unsigned)
SCALES, 5, number of Gaussian input scales (>=2); DoG outputs = SCALES-1
FRAME_W, 200, full-resolution frame width in pixels
FRAME_H, 200, full-resolution frame height in pixels
BORDER, 9, border margin in full-resolution pixels (window radius)
DOWN_S, 0, decimation exponent; keep 1 of every 2^DOWN_S in x and in y
DOG_OFFSET, 128, bias added to every difference
PIPE, 2, input-to-output latency in cycles (>=1)

Ports:
pixClk  in  1  clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-low (rst=0 at a rising pixClk edge resets)
in_valid  in  1  input pixel strobe
in_sof  in  1  start-of-frame; qualified by in_valid
in_gauss  in  SCALES*DATA_W  Gaussian samples; scale i in bits [i*DATA_W +: DATA_W]
out_valid  out  1  output pixel strobe
out_dog  out  (SCALES-1)*DATA_W  DoG i in bits [i*DATA_W +: DATA_W]
out_x  out  16  decimated column (full-res x >> DOWN_S)
out_y  out  16  decimated row
out_border  out  1  pixel lies inside the border margin
out_eof  out  1  last output pixel of the frame
sof_err  out  1  one-cycle pulse: in_sof arrived mid-frame

Behaviour:
- Reset: all outputs 0, x/y counters 0, FSM IDLE, pipeline valid bits cleared. A reset mid-frame discards in-flight pixels; no out_valid follows until a new in_sof.
- FSM IDLE: in_valid&in_sof -> RUN; that pixel is x=0,y=0. in_valid without in_sof is ignored.
- FSM RUN: each in_valid advances x; at x=FRAME_W-1, x wraps to 0 and y increments. The pixel at (FRAME_W-1,FRAME_H-1) is tagged eof; the FSM then returns to IDLE on the same edge.
- RUN with in_valid&in_sof: sof_err pulses one cycle after the edge. Counters restart so this pixel is (0,0). No eof is produced for the aborted frame.
- in_valid=0 leaves counters unchanged. There is no backpressure; the pipeline always advances, and bubbles appear as out_valid=0.
- Decimation keeps a pixel only when x[DOWN_S-1:0]==0 and y[DOWN_S-1:0]==0 (always kept when DOWN_S=0). Dropped pixels still advance the counters. out_eof is attached to the last kept pixel, at x=(FRAME_W-1)&~(2^DOWN_S-1) and the last kept row.
- Arithmetic per i in 0..SCALES-2: d = G[i+1] - G[i], signed, DATA_W+1 bits. s = d + DOG_OFFSET, computed with no overflow. out = 0 if s<0, 2^DATA_W-1 if s>2^DATA_W-1, else s.
- Border: set when x<BORDER, x>=FRAME_W-BORDER, y<BORDER or y>=FRAME_H-BORDER, using full-res coordinates. On border pixels every out_dog lane is forced to DOG_OFFSET.
- Latency: an input accepted at edge k produces out_valid, out_dog, out_x, out_y, out_border and out_eof after edge k+PIPE-1. These fields hold for one cycle only.
- Difference and saturation are registered in stage 1. Stages 2..PIPE are pure delay; all fields are delayed together.
- When out_valid=0, the data outputs hold their last values and out_eof=0.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with in_valid=1 -> all outputs 0. Release with in_valid=1, in_sof=0 -> out_valid stays 0.
2. Saturation (SCALES=3, BORDER=0, PIPE=2): G={0,255,128} -> DoG0=255 (383 clamped), DoG1=1. G={255,0,0} -> DoG0=0 (-127 clamped), DoG1=128. Each result appears 2 cycles after the input.
3. Frame sweep (FRAME_W=8, FRAME_H=4, BORDER=1, DOWN_S=0): 32 valid pixels, in_sof on the first -> 32 out_valid. out_x runs 0..7 and out_y runs 0..3; out_eof only at (7,3). out_border=1 on rows 0 and 3 and columns 0 and 7 (20 pixels), with out_dog=128 there.
4. Gaps: same frame with in_valid toggled 1,0,0,1... -> identical output sequence with matching bubbles, and out_eof still at (7,3).
5. Decimation DOWN_S=1, 8x4 frame -> 8 outputs. out_x runs 0..3 and out_y runs 0..1; out_eof is on full-res (6,2), which is output (3,1).
6. Mid-frame resync: in_sof at pixel 10 -> sof_err=1 for one cycle. The next output is (0,0), and a full 32-pixel frame follows with exactly one eof.
